agc_histogram: RTL and testbench

AGC_HISTOGRAM -- requirements
Module: agc_histogram

---
 rtl/agc_histogram_pkg.sv | 28 ++
 rtl/agc_histogram_if.sv | 23 ++
 rtl/agc_histogram_bin_popcount.sv | 33 +++
 rtl/agc_histogram.sv | 131 +++++++++++++
 tb/tb_agc_histogram.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/agc_histogram_pkg.sv
// Shared constants, FSM encoding and output word layout for the AGC histogram block.
package agc_histogram_pkg;

  localparam int NUM_BINS         = 32;
  localparam int SAMPLES_PER_BEAT = 8;
  localparam int SAMPLE_BITS      = 5;
  localparam int BEAT_BITS        = SAMPLES_PER_BEAT * SAMPLE_BITS;
  localparam int BIN_IDX_BITS     = 5;
  localparam int HIT_BITS         = 4;

  // hist_tdata layout: count in the low field, bin index at bit 24, rest zero
  localparam int TD_CNT_LSB = 0;
  localparam int TD_IDX_LSB = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } agc_state_e;

  // Offset-binary mapping: -16 lands in bin 0, 0 in bin 16, +15 in bin 31
  function automatic logic [BIN_IDX_BITS-1:0] bin_of(input logic [SAMPLE_BITS-1:0] smp);
    return smp ^ 5'h10;
  endfunction

endpackage

// File: rtl/agc_histogram_if.sv
// AXI4-Stream histogram output channel; master drives data/valid/last, slave drives ready.
interface agc_histogram_if;

  logic [31:0] hist_tdata;
  logic        hist_tvalid;
  logic        hist_tready;
  logic        hist_tlast;

  modport master (
    output hist_tdata,
    output hist_tvalid,
    output hist_tlast,
    input  hist_tready
  );

  modport slave (
    input  hist_tdata,
    input  hist_tvalid,
    input  hist_tlast,
    output hist_tready
  );

endinterface

// File: rtl/agc_histogram_bin_popcount.sv
// Per-beat bin hit counter: eight samples in, 32 registered 4-bit hit counts out (1 cycle).
module agc_bin_popcount
  import agc_histogram_pkg::*;
(
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic                                beat_vld,
  input  logic [BEAT_BITS-1:0]                beat_dat,
  output logic [NUM_BINS-1:0][HIT_BITS-1:0]   hits
);

  logic [NUM_BINS-1:0][HIT_BITS-1:0] hits_nxt;

  // An idle beat yields all-zero hits so the accumulator can add unconditionally
  always_comb begin
    hits_nxt = '0;
    if (beat_vld) begin
      for (int s = 0; s < SAMPLES_PER_BEAT; s++) begin
        hits_nxt[bin_of(beat_dat[s*SAMPLE_BITS +: SAMPLE_BITS])] =
          hits_nxt[bin_of(beat_dat[s*SAMPLE_BITS +: SAMPLE_BITS])] + 4'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hits <= '0;
    end else begin
      hits <= hits_nxt;
    end
  end

endmodule

// File: rtl/agc_histogram.sv
// AGC sample histogram: clears 32 bins, accumulates WINDOW_CLOCKS valid beats, then streams the bins out.
// Beats land in counters 3 cycles after acceptance; drain holds each word until hist_tready.
module agc_histogram
  import agc_histogram_pkg::*;
#(
  parameter int WINDOW_CLOCKS = 131072,
  parameter int COUNT_BITS    = 21
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [BEAT_BITS-1:0]  agc_dat_i,
  input  logic                  agc_valid_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  agc_histogram_if.master       hist
);

  localparam logic [2:0]  S_IDLE   = 3'(ST_IDLE);
  localparam logic [2:0]  S_CLEAR  = 3'(ST_CLEAR);
  localparam logic [2:0]  S_ACCUM  = 3'(ST_ACCUM);
  localparam logic [2:0]  S_FLUSH  = 3'(ST_FLUSH);
  localparam logic [2:0]  S_DRAIN  = 3'(ST_DRAIN);
  localparam logic [17:0] WIN_LAST = 18'(WINDOW_CLOCKS - 1);

  logic [2:0]                          state;
  logic [17:0]                         beat_cnt;
  logic [1:0]                          flush_cnt;
  logic [BIN_IDX_BITS-1:0]             drain_idx;
  logic                                s1_vld;
  logic [BEAT_BITS-1:0]                s1_dat;
  logic [NUM_BINS-1:0][HIT_BITS-1:0]   hits;
  logic [NUM_BINS-1:0][COUNT_BITS-1:0] bin_cnt;
  logic [NUM_BINS-1:0][COUNT_BITS-1:0] bin_cnt_nxt;
  logic                                accept;
  logic                                last_xfer;

  assign accept    = (state == S_ACCUM) && agc_valid_i;
  assign last_xfer = (state == S_DRAIN) && hist.hist_tready && (drain_idx == 5'd31);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      drain_idx <= '0;
    end else begin
      case (state)
        S_IDLE:  if (start_i) state <= S_CLEAR;
        S_CLEAR: begin
          beat_cnt <= '0;
          state    <= S_ACCUM;
        end
        S_ACCUM: if (agc_valid_i) begin
          beat_cnt <= beat_cnt + 18'd1;
          if (beat_cnt == WIN_LAST) begin
            state     <= S_FLUSH;
            flush_cnt <= '0;
          end
        end
        // Three cycles let the final beat clear both pipeline stages into the counters
        S_FLUSH: begin
          if (flush_cnt == 2'd2) begin
            state     <= S_DRAIN;
            drain_idx <= '0;
          end else begin
            flush_cnt <= flush_cnt + 2'd1;
          end
        end
        S_DRAIN: if (hist.hist_tready) begin
          drain_idx <= drain_idx + 5'd1;
          if (drain_idx == 5'd31) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_dat <= agc_dat_i;
    end
  end

  agc_bin_popcount u_popcount (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .beat_vld (s1_vld),
    .beat_dat (s1_dat),
    .hits     (hits)
  );

  always_comb begin : sat_add
    logic [COUNT_BITS:0] sum;
    bin_cnt_nxt = '0;
    sum         = '0;
    for (int b = 0; b < NUM_BINS; b++) begin
      sum            = {1'b0, bin_cnt[b]} + (COUNT_BITS+1)'(hits[b]);
      bin_cnt_nxt[b] = sum[COUNT_BITS] ? {COUNT_BITS{1'b1}} : sum[COUNT_BITS-1:0];
    end
  end

  // Counters keep their totals after the drain until the next run clears them
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bin_cnt <= '0;
    end else if (state == S_CLEAR) begin
      bin_cnt <= '0;
    end else begin
      bin_cnt <= bin_cnt_nxt;
    end
  end

  always_comb begin
    hist.hist_tdata = '0;
    if (state == S_DRAIN) begin
      hist.hist_tdata[TD_IDX_LSB +: BIN_IDX_BITS] = drain_idx;
      hist.hist_tdata[TD_CNT_LSB +: COUNT_BITS]   = bin_cnt[drain_idx];
    end
  end

  assign hist.hist_tvalid = (state == S_DRAIN);
  assign hist.hist_tlast  = (state == S_DRAIN) && (drain_idx == 5'd31);
  assign busy_o           = (state != S_IDLE);
  assign done_o           = last_xfer;

endmodule

// File: tb/tb_agc_histogram.sv
// Scoreboard bench for agc_histogram with a 16-beat window: model histograms are queued as beats are driven.
module tb_agc_histogram;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [39:0] agc_dat;
  logic        agc_valid;
  logic        start;
  logic        busy;
  logic        done;

  agc_histogram_if hist_if ();

  agc_histogram #(
    .WINDOW_CLOCKS (16),
    .COUNT_BITS    (21)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .agc_dat_i   (agc_dat),
    .agc_valid_i (agc_valid),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .hist        (hist_if)
  );

  always #5 aclk = ~aclk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          words_rx = 0;
  int          done_cnt = 0;
  int          first_tv = 0;
  int          t_start = 0;
  bit          tv_seen = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat = '0;
  logic [31:0] exp_q[$];
  int          hist_m[32];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // Output monitor: sampled mid-cycle, pops the scoreboard on each accepted word
  always @(negedge aclk) begin
    logic [31:0] e;
    logic [4:0]  ei;
    if (aresetn) begin
      if (hist_if.hist_tvalid && !tv_seen) begin
        tv_seen  = 1'b1;
        first_tv = cyc;
      end
      if (prev_stall && hist_if.hist_tvalid)
        check_val("stall_hold", hist_if.hist_tdata, prev_dat);
      prev_stall = hist_if.hist_tvalid && !hist_if.hist_tready;
      prev_dat   = hist_if.hist_tdata;
      if (hist_if.hist_tvalid && hist_if.hist_tready) begin
        words_rx++;
        check_val("word_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e  = exp_q.pop_front();
          ei = e[28:24];
          check_val("tdata", hist_if.hist_tdata, e);
          check_val("tlast", 32'(hist_if.hist_tlast), 32'(ei == 5'd31));
          check_val("done_pulse", 32'(done), 32'(ei == 5'd31));
        end
      end else if (done) begin
        check_val("done_no_xfer", 32'(done), 32'd0);
      end
      if (done) done_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [4:0] gen_sample(input int mode, input int lane);
    case (mode)
      0:       return 5'h00;
      1:       return (lane % 2 == 0) ? 5'h10 : 5'h0F;
      2:       return 5'($urandom_range(0, 31));
      3:       return 5'h01;
      default: return 5'h1F;
    endcase
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 right after done_o
  task automatic run_hist(input int mode, input bit stall, input bit restart, input int exp_lat);
    int          beats;
    int          c;
    logic [39:0] d;
    logic [4:0]  s;
    logic [31:0] w;
    for (int b = 0; b < 32; b++) hist_m[b] = 0;
    words_rx  = 0;
    done_cnt  = 0;
    tv_seen   = 1'b0;
    start     = 1'b1;
    agc_valid = 1'b0;
    t_start   = cyc;
    @(posedge aclk) #1;
    start = 1'b0;
    @(posedge aclk) #1;
    beats = 0;
    c     = 0;
    while (beats < 16) begin
      agc_valid = (mode == 1) ? (c % 2 == 0) : 1'b1;
      for (int l = 0; l < 8; l++) begin
        s            = gen_sample(mode, l);
        d[l*5 +: 5]  = s;
        if (agc_valid) hist_m[s ^ 5'h10]++;
      end
      agc_dat = d;
      if (agc_valid) beats++;
      start = restart && (c == 6);
      @(posedge aclk) #1;
      c++;
    end
    start = 1'b0;
    for (int b = 0; b < 32; b++) begin
      w        = '0;
      w[28:24] = 5'(b);
      w[20:0]  = 21'(hist_m[b]);
      exp_q.push_back(w);
    end
    // Beats offered after the window closes must not be counted
    hist_if.hist_tready = 1'b1;
    agc_valid = 1'b1;
    agc_dat   = {8{5'h05}};
    repeat (4) @(posedge aclk) #1;
    agc_valid = 1'b0;
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      hist_if.hist_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      start = restart && (i == 10);
      @(posedge aclk) #1;
    end
    start = 1'b0;
    hist_if.hist_tready = 1'b1;
    check_val("done_count", done_cnt, 1);
    check_val("word_count", words_rx, 32);
    check_val("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    if (exp_lat > 0) check_val("start_to_drain", first_tv - t_start, exp_lat);
    if (restart) begin
      repeat (3) @(posedge aclk) #1;
      check_val("idle_after_run", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    start = 1'b0;
    agc_valid = 1'b0;
    agc_dat = '0;
    hist_if.hist_tready = 1'b1;
    repeat (3) @(posedge aclk) #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_tvalid", 32'(hist_if.hist_tvalid), 32'd0);
    check_val("rst_tlast", 32'(hist_if.hist_tlast), 32'd0);
    check_val("rst_tdata", hist_if.hist_tdata, 32'd0);
    aresetn = 1'b1;
    repeat (2) @(posedge aclk) #1;
    check_val("idle_busy", 32'(busy), 32'd0);

    run_hist(0, 1'b0, 1'b0, 21);
    @(posedge aclk) #1;
    run_hist(1, 1'b0, 1'b0, 36);
    @(posedge aclk) #1;
    run_hist(2, 1'b1, 1'b0, 0);
    @(posedge aclk) #1;
    run_hist(2, 1'b1, 1'b1, 21);
    @(posedge aclk) #1;

    // Abort a run after eight accepted beats
    done_cnt = 0;
    words_rx = 0;
    start = 1'b1;
    @(posedge aclk) #1;
    start = 1'b0;
    @(posedge aclk) #1;
    agc_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      agc_dat = {$urandom, 8'($urandom)};
      @(posedge aclk) #1;
    end
    check_val("busy_before_abort", 32'(busy), 32'd1);
    aresetn = 1'b0;
    agc_valid = 1'b0;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_tvalid", 32'(hist_if.hist_tvalid), 32'd0);
    check_val("abort_tlast", 32'(hist_if.hist_tlast), 32'd0);
    check_val("abort_tdata", hist_if.hist_tdata, 32'd0);
    repeat (3) @(posedge aclk) #1;
    aresetn = 1'b1;
    repeat (40) @(posedge aclk) #1;
    check_val("abort_no_done", done_cnt, 0);
    check_val("abort_no_words", words_rx, 0);
    check_val("abort_idle", 32'(busy), 32'd0);
    run_hist(3, 1'b0, 1'b0, 21);
    @(posedge aclk) #1;

    // Back-to-back: second start lands in the cycle after done_o
    run_hist(2, 1'b0, 1'b0, 21);
    run_hist(4, 1'b1, 1'b0, 21);

    repeat (3) @(posedge aclk) #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
